inst_mem_resp: RTL

INST_MEM_RESP -- requirements
Module: inst_mem_resp

---
 rtl/inst_mem_resp_pkg.sv | 20 ++
 rtl/inst_mem_resp_load_word_asm.sv | 34 +++
 rtl/inst_mem_resp.sv | 104 ++++++++++
 3 files changed

// File: rtl/inst_mem_resp_pkg.sv
// Shared widths and constants for the instruction memory block and its program loader.
// Also holds the helper that caps a requested load length at the memory depth.
package inst_mem_resp_pkg;

  localparam int InstBus        = 32;
  localparam int InstAddrBus    = 32;
  localparam int InstMemNum     = 1024;
  localparam int InstMemNumLog2 = 10;
  localparam int LoadLenW       = 11;

  localparam logic [InstBus-1:0] ZeroWord   = '0;
  localparam logic               ChipEnable = 1'b1;
  localparam logic               JumpEnable = 1'b1;

  // A load can never write more words than the memory holds.
  function automatic logic [LoadLenW-1:0] clamp_len(input logic [LoadLenW-1:0] len);
    return (len > LoadLenW'(InstMemNum)) ? LoadLenW'(InstMemNum) : len;
  endfunction

endpackage

// File: rtl/inst_mem_resp_load_word_asm.sv
// Packs the loader byte stream into 32-bit words, little-endian.
// word_valid is combinational so the word is written in the cycle its 4th byte arrives.
module load_word_asm
  import inst_mem_resp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  input  logic [7:0]         byte_data,
  input  logic               byte_valid,
  output logic [InstBus-1:0] word,
  output logic               word_valid
);

  logic [1:0]  byte_cnt;
  logic [23:0] shift_q;
  logic        accept;

  assign accept     = en && byte_valid;
  assign word_valid = accept && (byte_cnt == 2'd3);
  assign word       = {byte_data, shift_q};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt <= '0;
      shift_q  <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      shift_q  <= {byte_data, shift_q[23:8]};
    end
  end

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction memory with a one-cycle fetch port and a byte-stream program loader.
// Fetches are blocked while a load is in progress; memory survives reset.
module inst_mem_resp
  import inst_mem_resp_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce_i,
  input  logic [InstAddrBus-1:0] addr_i,
  input  logic                   flush_i,
  output logic [InstBus-1:0]     inst_o,
  output logic                   inst_valid_o,
  output logic                   addr_err_o,
  input  logic                   load_start_i,
  input  logic [LoadLenW-1:0]    load_len_i,
  input  logic [7:0]             load_byte_i,
  input  logic                   load_byte_valid_i,
  output logic                   load_busy_o,
  output logic                   load_done_o
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                    state, state_nxt;
  logic [InstMemNumLog2-1:0] wr_addr;
  logic [LoadLenW-1:0]       words_left;
  logic [InstBus-1:0]        mem [InstMemNum];
  logic [InstBus-1:0]        asm_word;
  logic                      asm_valid;
  logic                      start;
  logic                      last_word;
  logic                      fetch;

  assign start     = (state == IDLE) && load_start_i;
  assign last_word = asm_valid && (words_left == LoadLenW'(1));
  assign fetch     = (ce_i == ChipEnable) && (flush_i != JumpEnable) && (state != LOAD);

  load_word_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .en         (state == LOAD),
    .byte_data  (load_byte_i),
    .byte_valid (load_byte_valid_i),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_start_i) state_nxt = (load_len_i == '0) ? DONE : LOAD;
      LOAD:    if (last_word) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_addr    <= '0;
      words_left <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        wr_addr    <= '0;
        words_left <= clamp_len(load_len_i);
      end else if (asm_valid) begin
        words_left <= words_left - LoadLenW'(1);
        if (wr_addr != '1) wr_addr <= wr_addr + 1'b1;
      end
    end
  end

  // No reset on the array: program contents must survive a reset.
  always_ff @(posedge clk) begin
    if (!rst && asm_valid) mem[wr_addr] <= asm_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_o       <= ZeroWord;
      inst_valid_o <= 1'b0;
      addr_err_o   <= 1'b0;
    end else begin
      inst_o       <= ZeroWord;
      inst_valid_o <= 1'b0;
      addr_err_o   <= 1'b0;
      if (fetch) begin
        if (addr_i[InstAddrBus-1:InstMemNumLog2] == '0) begin
          inst_o       <= mem[addr_i[InstMemNumLog2-1:0]];
          inst_valid_o <= 1'b1;
        end else begin
          addr_err_o <= 1'b1;
        end
      end
    end
  end

  assign load_busy_o = (state == LOAD);
  assign load_done_o = (state == DONE);

endmodule
